// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the 8227 memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    // Bus ownership: CPU by default, DMA while granted, CPU for one forced cycle after a full burst
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_DMA   = 2'd1,
        ARB_YIELD = 2'd2
    } arb_state_t;

    // Counter wide enough to hold MAX_BURST itself, so it can saturate instead of wrapping
    function automatic int burst_cnt_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter8227_if.sv
// CPU, DMA and memory bus signals of the arbiter, grouped as one interface.
interface mem_arbiter8227_if;
    import mem_arb_pkg::*;

    // CPU side
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_rnw;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ready;

    // DMA / loader side
    logic              dma_req;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_we;
    logic              dma_gnt;
    logic              dma_ack;
    logic [DATA_W-1:0] dma_rdata;

    // Memory side
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_en;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    // The arbiter itself
    modport slave (
        input  cpu_addr, cpu_wdata, cpu_rnw,
        output cpu_rdata, cpu_ready,
        input  dma_req, dma_addr, dma_wdata, dma_we,
        output dma_gnt, dma_ack, dma_rdata,
        output mem_addr, mem_wdata, mem_en, mem_we,
        input  mem_rdata
    );

    // The surrounding CPU, DMA engine and memory
    modport master (
        output cpu_addr, cpu_wdata, cpu_rnw,
        input  cpu_rdata, cpu_ready,
        output dma_req, dma_addr, dma_wdata, dma_we,
        input  dma_gnt, dma_ack, dma_rdata,
        input  mem_addr, mem_wdata, mem_en, mem_we,
        output mem_rdata
    );

endinterface

// File: rtl/mem_arbiter8227_burst_counter.sv
// Counts DMA accesses within one burst; flags the last allowed access.
module arb_burst_counter
    import mem_arb_pkg::*;
#(
    parameter  int MAX_BURST = 4,
    localparam int CNT_W     = burst_cnt_w(MAX_BURST)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(MAX_BURST - 1);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    // Next count: clear wins over increment, and the count saturates at MAX_BURST
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == CNT_TC);

endmodule

// File: rtl/mem_arbiter8227.sv
// Single-port memory arbiter: DMA steals CPU read cycles only, in capped bursts.
module mem_arbiter8227
    import mem_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input logic              clk,
    input logic              rst,
    mem_arbiter8227_if.slave bus
);

    localparam int CNT_W = burst_cnt_w(MAX_BURST);

    arb_state_t        state_d, state_q;
    logic              rst_seen_d, rst_seen_q;
    logic              cpu_rd_d, cpu_rd_q;
    logic [DATA_W-1:0] hold_d, hold_q;
    logic              dma_ack_d, dma_ack_q;

    logic              burst_clr, burst_inc, burst_tc;
    logic [CNT_W-1:0]  burst_cnt;

    logic              dma_owns;
    logic              bus_quiet;

    assign dma_owns  = (state_q == ARB_DMA);
    // No memory access while in reset and in the first cycle after it
    assign bus_quiet = rst || rst_seen_q;

    arb_burst_counter #(
        .MAX_BURST (MAX_BURST)
    ) u_burst_counter (
        .clk (clk),
        .rst (rst),
        .clr (burst_clr),
        .inc (burst_inc),
        .cnt (burst_cnt),
        .tc  (burst_tc)
    );

    // Next-state logic: enter DMA only on a CPU read, leave after a capped burst via YIELD
    always_comb begin
        state_d   = state_q;
        burst_clr = 1'b0;
        burst_inc = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (bus.dma_req && bus.cpu_rnw) begin
                    state_d   = ARB_DMA;
                    burst_clr = 1'b1;
                end
            end
            ARB_DMA: begin
                if (!bus.dma_req) begin
                    state_d = ARB_IDLE;
                end else begin
                    burst_inc = 1'b1;
                    if (burst_tc) begin
                        state_d = ARB_YIELD;
                    end
                end
            end
            ARB_YIELD: state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    // Memory mux and strobes; the CPU owns the bus outside ARB_DMA
    always_comb begin
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
        bus.mem_en    = 1'b1;
        bus.mem_we    = !bus.cpu_rnw;
        if (dma_owns) begin
            bus.mem_addr  = bus.dma_addr;
            bus.mem_wdata = bus.dma_wdata;
            bus.mem_en    = bus.dma_req;
            bus.mem_we    = bus.dma_req && bus.dma_we;
        end
        if (bus_quiet) begin
            bus.mem_en = 1'b0;
            bus.mem_we = 1'b0;
        end
    end

    // Next values of the read-tracking, hold and acknowledge registers
    always_comb begin
        rst_seen_d = 1'b0;
        cpu_rd_d   = !dma_owns && bus.cpu_rnw && !bus_quiet;
        dma_ack_d  = dma_owns && bus.dma_req && !rst;
        hold_d     = cpu_rd_q ? bus.mem_rdata : hold_q;
    end

    // Handshake outputs come from registered state; reset only forces them to idle values
    always_comb begin
        bus.cpu_ready = !dma_owns;
        bus.dma_gnt   = dma_owns;
        bus.dma_ack   = dma_ack_q;
        bus.cpu_rdata = cpu_rd_q ? bus.mem_rdata : hold_q;
        bus.dma_rdata = bus.mem_rdata;
        if (rst) begin
            bus.cpu_ready = 1'b1;
            bus.dma_gnt   = 1'b0;
            bus.dma_ack   = 1'b0;
            bus.cpu_rdata = '0;
        end
    end

    // State and data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            rst_seen_q <= 1'b1;
            cpu_rd_q   <= 1'b0;
            dma_ack_q  <= 1'b0;
            // NOTE: the hold register is reset because its value reaches cpu_rdata directly.
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            rst_seen_q <= rst_seen_d;
            cpu_rd_q   <= cpu_rd_d;
            dma_ack_q  <= dma_ack_d;
            hold_q     <= hold_d;
        end
    end

    // The saturating counter can never exceed the burst cap
    always_comb begin
        assert (burst_cnt <= CNT_W'(MAX_BURST));
    end

endmodule

// File: tb/tb_mem_arbiter8227.sv
// Self-checking bench: directed vector table, burst/reset sequences, random run vs. model.
`timescale 1ns/1ps
module tb_mem_arbiter8227;
    import mem_arb_pkg::*;

    localparam int MAX_BURST = 4;
    localparam int N_VEC     = 12;
    localparam int N_RAND    = 400;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter8227_if bus ();

    mem_arbiter8227 #(.MAX_BURST(MAX_BURST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Synchronous single-port memory behind the arbiter
    logic [7:0] tb_mem [0:65535];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) tb_mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= tb_mem[bus.mem_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [15:0] ca, input logic [7:0] cw, input logic rnw,
                         input logic req, input logic [15:0] da, input logic [7:0] dw,
                         input logic dwe);
        bus.cpu_addr  = ca;
        bus.cpu_wdata = cw;
        bus.cpu_rnw   = rnw;
        bus.dma_req   = req;
        bus.dma_addr  = da;
        bus.dma_wdata = dw;
        bus.dma_we    = dwe;
    endtask

    typedef struct {
        logic [15:0] ca;  logic [7:0] cw;  logic rnw;
        logic        req; logic [15:0] da; logic [7:0] dw; logic dwe;
        logic        ready, gnt, ack, en, we;
        logic [15:0] maddr;
        logic [7:0]  crd;
        logic        dchk;  logic [7:0] drd;
        logic        probe; logic [15:0] paddr; logic [7:0] pval;
    } vec_t;

    vec_t vecs [N_VEC];

    // Behavioural model state for the random phase
    logic [7:0] ref_mem [0:15];
    bit         m_gnt, m_yield, m_fresh, m_ack, m_ack_rd;
    int         m_run;
    logic [7:0] m_last_cpu, m_dma_rd;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 65536; i++) tb_mem[i] = 8'h00;
        tb_mem[16'hCCDD] = 8'hA5;
        tb_mem[16'hCCDE] = 8'h99;
        tb_mem[16'h0099] = 8'h73;

        //                ca        cw     rnw   req   da        dw     dwe   rdy   gnt   ack   en    we    maddr     crd    dchk  drd    probe paddr     pval
        vecs[0]  = '{16'hCCDD, 8'h00, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'hCCDD, 8'h00, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00};
        vecs[1]  = '{16'hCCDD, 8'h00, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'hCCDD, 8'h00, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00};
        vecs[2]  = '{16'hCCDD, 8'h00, 1'b1, 1'b1, 16'h0050, 8'h73, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'hCCDD, 8'hA5, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00};
        vecs[3]  = '{16'hCCDD, 8'h00, 1'b1, 1'b1, 16'h0050, 8'h73, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0050, 8'hA5, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00};
        vecs[4]  = '{16'hCCDD, 8'h00, 1'b1, 1'b0, 16'h0050, 8'h73, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0050, 8'hA5, 1'b0, 8'h00, 1'b1, 16'h0050, 8'h73};
        vecs[5]  = '{16'hCCDD, 8'h00, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'hCCDD, 8'hA5, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00};
        vecs[6]  = '{16'h0050, 8'h42, 1'b0, 1'b1, 16'h0099, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0050, 8'hA5, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00};
        vecs[7]  = '{16'hCCDD, 8'h00, 1'b1, 1'b1, 16'h0099, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'hCCDD, 8'hA5, 1'b0, 8'h00, 1'b1, 16'h0050, 8'h42};
        vecs[8]  = '{16'hCCDE, 8'h00, 1'b1, 1'b1, 16'h0099, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0099, 8'hA5, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00};
        vecs[9]  = '{16'hCCDE, 8'h00, 1'b1, 1'b0, 16'h0099, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0099, 8'hA5, 1'b1, 8'h73, 1'b0, 16'h0000, 8'h00};
        vecs[10] = '{16'hCCDE, 8'h00, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'hCCDE, 8'hA5, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00};
        vecs[11] = '{16'hCCDE, 8'h00, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'hCCDE, 8'h99, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00};

        // Reset values while rst is held
        rst = 1'b1;
        drive(16'hCCDD, 8'h00, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        check("rst cpu_ready", bus.cpu_ready, 1'b1);
        check("rst dma_gnt",   bus.dma_gnt,   1'b0);
        check("rst dma_ack",   bus.dma_ack,   1'b0);
        check("rst mem_en",    bus.mem_en,    1'b0);
        check("rst mem_we",    bus.mem_we,    1'b0);
        check("rst cpu_rdata", bus.cpu_rdata, 8'h00);

        // Directed table: first cycle after reset, CPU read, DMA write, CPU write hold-off, DMA read during stall
        for (int i = 0; i < N_VEC; i++) begin
            @(negedge clk);
            rst = 1'b0;
            drive(vecs[i].ca, vecs[i].cw, vecs[i].rnw, vecs[i].req, vecs[i].da, vecs[i].dw, vecs[i].dwe);
            #1;
            check($sformatf("v%0d cpu_ready", i), bus.cpu_ready, vecs[i].ready);
            check($sformatf("v%0d dma_gnt", i),   bus.dma_gnt,   vecs[i].gnt);
            check($sformatf("v%0d dma_ack", i),   bus.dma_ack,   vecs[i].ack);
            check($sformatf("v%0d mem_en", i),    bus.mem_en,    vecs[i].en);
            check($sformatf("v%0d mem_we", i),    bus.mem_we,    vecs[i].we);
            check($sformatf("v%0d mem_addr", i),  bus.mem_addr,  vecs[i].maddr);
            check($sformatf("v%0d cpu_rdata", i), bus.cpu_rdata, vecs[i].crd);
            if (vecs[i].dchk)  check($sformatf("v%0d dma_rdata", i), bus.dma_rdata, vecs[i].drd);
            if (vecs[i].probe) check($sformatf("v%0d mem probe", i), tb_mem[vecs[i].paddr], vecs[i].pval);
        end

        // Continuous DMA requests: MAX_BURST grants, YIELD, IDLE, regrant
        for (int k = 0; k < 18; k++) begin
            logic exp_gnt, exp_ack;
            @(negedge clk);
            drive(16'hCCDD, 8'h00, 1'b1, 1'b1, 16'h0100 + 16'(k), 8'(k), 1'b1);
            #1;
            exp_gnt = (k >= 1) && (((k - 1) % (MAX_BURST + 2)) < MAX_BURST);
            exp_ack = (k >= 2) && (((k - 2) % (MAX_BURST + 2)) < MAX_BURST);
            check($sformatf("burst c%0d dma_gnt", k),   bus.dma_gnt,   exp_gnt);
            check($sformatf("burst c%0d cpu_ready", k), bus.cpu_ready, !exp_gnt);
            check($sformatf("burst c%0d dma_ack", k),   bus.dma_ack,   exp_ack);
        end
        @(negedge clk);
        drive(16'hCCDD, 8'h00, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0);
        #1;
        check("burst end mem 0x0108", tb_mem[16'h0108], 8'h08);

        // Reset during the second access of a burst
        @(negedge clk);
        drive(16'hCCDD, 8'h00, 1'b1, 1'b1, 16'h0076, 8'hDD, 1'b1);
        #1;
        check("abort c0 dma_gnt", bus.dma_gnt, 1'b0);
        @(negedge clk);
        #1;
        check("abort c1 dma_gnt", bus.dma_gnt, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        drive(16'hCCDD, 8'h00, 1'b1, 1'b1, 16'h0077, 8'hEE, 1'b1);
        #1;
        check("abort c2 mem_en", bus.mem_en, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(16'hCCDD, 8'h00, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0);
        #1;
        check("abort state",     32'(dut.state_q),   32'(ARB_IDLE));
        check("abort burst_cnt", 32'(dut.burst_cnt), 32'd0);
        check("abort dma_gnt",   bus.dma_gnt,   1'b0);
        check("abort dma_ack",   bus.dma_ack,   1'b0);
        check("abort cpu_ready", bus.cpu_ready, 1'b1);
        check("abort mem 0x0076", tb_mem[16'h0076], 8'hDD);
        check("abort mem 0x0077", tb_mem[16'h0077], 8'h00);

        // Random run against the behavioural model over a 16-byte window
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int a = 0; a < 16; a++) ref_mem[a] = tb_mem[a];
        m_gnt = 0; m_yield = 0; m_fresh = 1; m_ack = 0; m_ack_rd = 0;
        m_run = 0; m_last_cpu = 8'h00; m_dma_rd = 8'h00;
        for (int c = 0; c < N_RAND; c++) begin
            logic [3:0] ca4, da4;
            logic [7:0] cw, dw, rd_cpu, rd_dma;
            logic       rnw, req, dwe;
            bit         acc_dma, acc_cpu, n_gnt, n_yield;
            int         n_run;
            ca4 = 4'($urandom_range(15));
            da4 = 4'($urandom_range(15));
            cw  = 8'($urandom_range(255));
            dw  = 8'($urandom_range(255));
            rnw = ($urandom_range(3) != 0);
            req = ($urandom_range(9) < 6);
            dwe = ($urandom_range(1) != 0);
            @(negedge clk);
            rst = 1'b0;
            drive({12'h000, ca4}, cw, rnw, req, {12'h000, da4}, dw, dwe);
            #1;
            check($sformatf("rnd%0d cpu_ready", c), bus.cpu_ready, !m_gnt);
            check($sformatf("rnd%0d dma_gnt", c),   bus.dma_gnt,   m_gnt);
            check($sformatf("rnd%0d dma_ack", c),   bus.dma_ack,   m_ack);
            check($sformatf("rnd%0d cpu_rdata", c), bus.cpu_rdata, m_last_cpu);
            if (m_ack && m_ack_rd) check($sformatf("rnd%0d dma_rdata", c), bus.dma_rdata, m_dma_rd);

            // Who uses the memory this cycle, and what it sees
            acc_dma = m_gnt && req;
            acc_cpu = !m_gnt && !m_fresh;
            rd_cpu  = ref_mem[ca4];
            rd_dma  = ref_mem[da4];
            if (acc_dma && dwe)  ref_mem[da4] = dw;
            if (acc_cpu && !rnw) ref_mem[ca4] = cw;
            if (acc_cpu && rnw)  m_last_cpu = rd_cpu;
            if (acc_dma)         m_dma_rd = rd_dma;
            m_ack    = acc_dma;
            m_ack_rd = acc_dma && !dwe;

            // Ownership next cycle: bursts end on idle request or after MAX_BURST accesses
            if (m_gnt) begin
                n_run   = m_run + (req ? 1 : 0);
                n_gnt   = req && (n_run < MAX_BURST);
                n_yield = req && (n_run == MAX_BURST);
            end else begin
                n_run   = 0;
                n_gnt   = req && rnw && !m_yield;
                n_yield = 0;
            end
            m_gnt   = n_gnt;
            m_yield = n_yield;
            m_run   = n_run;
            m_fresh = 0;
        end
        @(negedge clk);
        drive(16'hCCDD, 8'h00, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0);
        @(negedge clk);
        for (int a = 0; a < 16; a++) begin
            check($sformatf("rnd mem[%0d]", a), tb_mem[a], ref_mem[a]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
